// File: rtl/cv32e40s_irq_gateway.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cv32e40s_irq_gateway
// Purpose  : Synchronises external interrupt pins and conditions each line as
//            level-sensitive or rising-edge-to-sticky-pending for the core.
// Revision : 1.0 - initial release
// ============================================================================
module cv32e40s_irq_gateway #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter logic [31:0] EDGE_CAPABLE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] irq_i,
    input  logic [31:0] edge_en_i,
    input  logic        irq_ack_i,
    input  logic [4:0]  irq_ack_id_i,
    output logic [31:0] irq_o,
    output logic [31:0] irq_wu_o,
    output logic [31:0] overrun_o
);

    localparam logic [31:0] IRQ_MASK   = 32'hFFFF_0888;
    // MSI/MTI/MEI are architecturally level-sensitive
    localparam logic [31:0] LEVEL_ONLY = 32'h0000_0888;

    generate
        if (SYNC_STAGES < 1 || SYNC_STAGES > 3) begin : g_bad_sync_stages
            $error("cv32e40s_irq_gateway: SYNC_STAGES must be in 1..3");
        end
    endgenerate

    logic [31:0] sync_d [SYNC_STAGES];
    logic [31:0] sync_q [SYNC_STAGES];
    logic [31:0] sync;
    logic [31:0] hist_d, hist_q;
    logic [31:0] pending_d, pending_q;
    logic [31:0] overrun_d, overrun_q;
    logic [31:0] eff_edge_d, eff_edge_q;
    logic [31:0] eff_edge;
    logic [31:0] rise;
    logic [31:0] clr;
    logic [31:0] keep;

    // Masked lines enter the chain as 0, so every downstream flop stays 0 for them
    assign sync_d[0] = irq_i & IRQ_MASK;

    generate
        for (genvar k = 1; k < SYNC_STAGES; k++) begin : g_sync_link
            assign sync_d[k] = sync_q[k-1];
        end
        for (genvar k = 0; k < SYNC_STAGES; k++) begin : g_sync_ff
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_q[k] <= '0;
                end else begin
                    sync_q[k] <= sync_d[k];
                end
            end
        end
    endgenerate

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        clr = '0;
        if (irq_ack_i) begin
            clr[irq_ack_id_i] = 1'b1;
        end
    end

    always_comb begin
        eff_edge   = edge_en_i & EDGE_CAPABLE & IRQ_MASK & ~LEVEL_ONLY;
        eff_edge_d = eff_edge;
        hist_d     = sync;
        rise       = sync & ~hist_q;
        // A mode flip (either way) or level mode wipes edge state; set does not win
        keep       = eff_edge & ~(eff_edge ^ eff_edge_q);
        pending_d  = keep & (rise | (pending_q & ~clr));
        overrun_d  = keep & ((rise & pending_q & ~clr) | (overrun_q & ~clr));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q     <= '0;
            pending_q  <= '0;
            overrun_q  <= '0;
            eff_edge_q <= '0;
        end else begin
            hist_q     <= hist_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            eff_edge_q <= eff_edge_d;
        end
    end

    assign irq_o     = (eff_edge & pending_q) | (~eff_edge & sync);
    assign irq_wu_o  = (irq_i | (eff_edge & pending_q)) & IRQ_MASK;
    assign overrun_o = overrun_q & IRQ_MASK;

endmodule
`default_nettype wire

// File: tb/tb_cv32e40s_irq_gateway.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cv32e40s_irq_gateway
// Purpose  : Randomised scoreboard bench for the interrupt gateway.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cv32e40s_irq_gateway;

    localparam int          S           = 2;
    localparam logic [31:0] MASK        = 32'hFFFF_0888;
    localparam logic [31:0] EDGE_CAP    = 32'hFFFF_0000;
    localparam logic [31:0] FIXED_LEVEL = 32'h0000_0888;

    logic        clk = 1'b0;
    bit          clk_run = 1'b1;
    logic        rst_n;
    logic [31:0] irq_i, edge_en_i;
    logic        irq_ack_i;
    logic [4:0]  irq_ack_id_i;
    logic [31:0] irq_o, irq_wu_o, overrun_o;

    always #5 if (clk_run) clk = ~clk;

    cv32e40s_irq_gateway #(.SYNC_STAGES(S), .EDGE_CAPABLE(EDGE_CAP)) dut (
        .clk(clk), .rst_n(rst_n), .irq_i(irq_i), .edge_en_i(edge_en_i),
        .irq_ack_i(irq_ack_i), .irq_ack_id_i(irq_ack_id_i),
        .irq_o(irq_o), .irq_wu_o(irq_wu_o), .overrun_o(overrun_o)
    );

    typedef struct {
        logic [31:0] irq;
        logic [31:0] ovr;
        logic [31:0] wu;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;

    // Reference model: history of sampled pins plus per-line pending/overrun bits
    logic [31:0] samp_q[$];
    logic [31:0] m_pend, m_ovr, m_eff_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] eff_of(input logic [31:0] en);
        return en & EDGE_CAP & MASK & ~FIXED_LEVEL;
    endfunction

    task automatic model_reset();
        samp_q = {};
        for (int j = 0; j <= S; j++) samp_q.push_back(32'h0);
        m_pend = '0;
        m_ovr = '0;
        m_eff_prev = '0;
    endtask

    // Applies the inputs present at the clock edge just taken
    task automatic model_edge();
        logic [31:0] sync, hist, eff;
        logic r, c;
        sync = samp_q[1];
        hist = samp_q[0];
        eff  = eff_of(edge_en_i);
        for (int i = 0; i < 32; i++) begin
            if (!eff[i] || (eff[i] != m_eff_prev[i])) begin
                m_pend[i] = 1'b0;
                m_ovr[i]  = 1'b0;
            end else begin
                c = irq_ack_i && (irq_ack_id_i == 5'(i));
                r = sync[i] && !hist[i];
                if (c) m_ovr[i] = 1'b0;
                else if (r && m_pend[i]) m_ovr[i] = 1'b1;
                m_pend[i] = r || (m_pend[i] && !c);
            end
        end
        m_eff_prev = eff;
        samp_q.push_back(irq_i & MASK);
        void'(samp_q.pop_front());
    endtask

    function automatic exp_t model_out();
        exp_t e;
        logic [31:0] eff;
        eff = eff_of(edge_en_i);
        for (int i = 0; i < 32; i++) e.irq[i] = eff[i] ? m_pend[i] : samp_q[1][i];
        e.ovr = m_ovr;
        e.wu  = (irq_i | (eff & m_pend)) & MASK;
        return e;
    endfunction

    task automatic randomize_inputs(input int p_tog, input int p_en, input int p_ack);
        int id;
        for (int i = 0; i < 32; i++) begin
            if ($urandom_range(0, 99) < p_tog) irq_i[i] = ~irq_i[i];
            if ($urandom_range(0, 99) < p_en) edge_en_i[i] = ~edge_en_i[i];
        end
        irq_ack_i = ($urandom_range(0, 99) < p_ack);
        id = $urandom_range(0, 31);
        if (m_pend != 0 && $urandom_range(0, 1) == 1) begin
            for (int t = 0; t < 64 && !m_pend[id]; t++) id = $urandom_range(0, 31);
        end
        irq_ack_id_i = 5'(id);
    endtask

    task automatic cycle(input int p_tog, input int p_en, input int p_ack);
        @(posedge clk);
        #1;
        model_edge();
        randomize_inputs(p_tog, p_en, p_ack);
        exp_q.push_back(model_out());
        mon_en = 1'b1;
    endtask

    task automatic quiesce_monitor();
        @(negedge clk);
        #1;
        mon_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty no expected entry at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("irq_o", irq_o, e.irq);
                chk("overrun_o", overrun_o, e.ovr);
                chk("irq_wu_o", irq_wu_o, e.wu);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        irq_i = 32'h0000_0808;
        edge_en_i = $urandom;
        irq_ack_i = 1'b0;
        irq_ack_id_i = '0;
        #2;
        chk("reset_irq_o", irq_o, 32'h0);
        chk("reset_overrun_o", overrun_o, 32'h0);
        chk("reset_wu", irq_wu_o, 32'h0000_0808);
        irq_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        for (int n = 0; n < 800; n++) cycle(10, 1, 20);
        for (int n = 0; n < 500; n++) cycle(30, 0, 40);

        // Asynchronous reset mid-operation, between clock edges
        quiesce_monitor();
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_irq_o", irq_o, 32'h0);
        chk("midreset_overrun_o", overrun_o, 32'h0);
        chk("midreset_wu", irq_wu_o, irq_i & MASK);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        edge_en_i = 32'hFFFF_FFFF;
        for (int n = 0; n < 600; n++) cycle(5, 2, 10);

        // Wake-up view with the clock stopped
        quiesce_monitor();
        clk_run = 1'b0;
        #20;
        irq_i = 32'h0000_0008;
        #1;
        chk("stopped_wu_line3", irq_wu_o, model_out().wu);
        for (int n = 0; n < 6; n++) begin
            irq_i = $urandom;
            #2;
            chk("stopped_wu_rand", irq_wu_o, model_out().wu);
        end
        clk_run = 1'b1;

        for (int n = 0; n < 600; n++) cycle(15, 3, 30);
        quiesce_monitor();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
